// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared types, segment constants and double-dabble helper for the BCD display
package sseg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV_A = 3'd1,
    CONV_B = 3'd2,
    CONV_R = 3'd3,
    COMMIT = 3'd4
  } state_t;

  // Active-low segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Widths of the 3-digit operand fields and the 5-digit result field
  localparam int BCD3_W = 12;
  localparam int BCD5_W = 20;

  // Encodings of field_sel
  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_A    = 2'd1;
  localparam logic [1:0] FIELD_B    = 2'd2;
  localparam logic [1:0] FIELD_R    = 2'd3;

  // Pre-shift correction: every nibble of 5 or more gets 3 added so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD5_W-1:0] dd_adjust(input logic [BCD5_W-1:0] bcd);
    logic [BCD5_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD5_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/sseg_bcd_display_bcd_to_sseg.sv
// rtl/sseg_bcd_display_bcd_to_sseg.sv - one BCD digit plus blank flag to active-low segments
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Decode the digit; blank flag and non-decimal codes both turn the digit off
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sseg_bcd_display.sv
// rtl/sseg_bcd_display.sv - latches operands/product, converts to BCD serially and drives eight digits
module sseg_bcd_display
  import sseg_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000,
  parameter int BLINK_W   = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        update,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  input  logic [15:0] result,
  input  logic        show_result,
  input  logic [1:0]  field_sel,
  output logic        busy,
  output logic        done,
  output logic [6:0]  ssegment0,
  output logic [6:0]  ssegment1,
  output logic [6:0]  ssegment2,
  output logic [6:0]  ssegment3,
  output logic [6:0]  ssegment4,
  output logic [6:0]  ssegment5,
  output logic [6:0]  ssegment6,
  output logic [6:0]  ssegment7
);

  state_t              r_state;
  state_t              w_next_state;

  // Shared conversion datapath: one shift source, one BCD accumulator
  logic [3:0]          r_bit_cnt;
  logic [15:0]         r_shift;
  logic [BCD5_W-1:0]   r_bcd;
  logic [7:0]          r_op_b;
  logic [15:0]         r_result;
  logic [BCD3_W-1:0]   r_bcd_a;
  logic [BCD3_W-1:0]   r_bcd_b;

  // Committed display values; r_disp_valid stays low until the first commit
  logic [BCD3_W-1:0]   r_disp_a;
  logic [BCD3_W-1:0]   r_disp_b;
  logic [BCD5_W-1:0]   r_disp_r;
  logic                r_disp_valid;

  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink_phase;

  logic [BCD5_W-1:0]   w_adj;
  logic [BCD5_W-1:0]   w_bcd_shift;
  logic                w_last;
  logic                w_blink_a;
  logic                w_blink_b;
  logic                w_blink_r;
  logic [3:0]          w_digit [8];
  logic                w_blank [8];
  logic [6:0]          w_seg   [8];

  assign w_adj       = dd_adjust(r_bcd);
  assign w_bcd_shift = BCD5_W'({w_adj, r_shift[15]});
  assign w_last      = (r_state == CONV_R) ? (r_bit_cnt == 4'd15) : (r_bit_cnt == 4'd7);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: fixed-length conversion phases, updates accepted only in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (update) w_next_state = CONV_A;
      CONV_A:  if (w_last) w_next_state = CONV_B;
      CONV_B:  if (w_last) w_next_state = CONV_R;
      CONV_R:  if (w_last) w_next_state = COMMIT;
      COMMIT:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == COMMIT);
  end

  // Conversion datapath: capture, shift one bit per cycle, hand off between phases, commit
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_bcd        <= '0;
      r_op_b       <= '0;
      r_result     <= '0;
      r_bcd_a      <= '0;
      r_bcd_b      <= '0;
      r_disp_a     <= '0;
      r_disp_b     <= '0;
      r_disp_r     <= '0;
      r_disp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (update) begin
            r_shift   <= {op_a, 8'h00};
            r_op_b    <= op_b;
            r_result  <= result;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
          end
        end
        CONV_A, CONV_B, CONV_R: begin
          r_bcd     <= w_bcd_shift;
          r_shift   <= r_shift << 1;
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (w_last) begin
            r_bit_cnt <= '0;
            if (r_state == CONV_A) begin
              r_bcd_a <= w_bcd_shift[BCD3_W-1:0];
              r_bcd   <= '0;
              r_shift <= {r_op_b, 8'h00};
            end else if (r_state == CONV_B) begin
              r_bcd_b <= w_bcd_shift[BCD3_W-1:0];
              r_bcd   <= '0;
              r_shift <= r_result;
            end
          end
        end
        COMMIT: begin
          r_disp_a     <= r_bcd_a;
          r_disp_b     <= r_bcd_b;
          r_disp_r     <= r_bcd;
          r_disp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Free-running blink timebase; the phase flips each time the counter wraps
  always_ff @(posedge clock) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  // A field blinks only while it is actually on screen
  always_comb begin
    w_blink_a = r_blink_phase && !show_result && (field_sel == FIELD_A);
    w_blink_b = r_blink_phase && !show_result && (field_sel == FIELD_B);
    w_blink_r = r_blink_phase &&  show_result && (field_sel == FIELD_R);
  end

  // Digit routing per view with leading-zero blanking; the ones digit is always shown
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_digit[i] = 4'd0;
      w_blank[i] = 1'b1;
    end
    if (r_disp_valid) begin
      if (show_result) begin
        for (int i = 0; i < 5; i++) begin
          w_digit[i] = r_disp_r[4*i +: 4];
          w_blank[i] = w_blink_r || ((i != 0) && ((r_disp_r >> (4*i)) == '0));
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          w_digit[i+5] = r_disp_a[4*i +: 4];
          w_blank[i+5] = w_blink_a || ((i != 0) && ((r_disp_a >> (4*i)) == '0));
          w_digit[i]   = r_disp_b[4*i +: 4];
          w_blank[i]   = w_blink_b || ((i != 0) && ((r_disp_b >> (4*i)) == '0));
        end
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_dec
    bcd_to_sseg u_dec (
      .i_digit (w_digit[g]),
      .i_blank (w_blank[g]),
      .o_seg   (w_seg[g])
    );
  end

  assign ssegment0 = w_seg[0];
  assign ssegment1 = w_seg[1];
  assign ssegment2 = w_seg[2];
  assign ssegment3 = w_seg[3];
  assign ssegment4 = w_seg[4];
  assign ssegment5 = w_seg[5];
  assign ssegment6 = w_seg[6];
  assign ssegment7 = w_seg[7];

endmodule

// File: tb/tb_sseg_bcd_display.sv
// tb/tb_sseg_bcd_display.sv - randomized and directed self-checking bench for sseg_bcd_display
module tb_sseg_bcd_display;

  localparam int BD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        update = 1'b0;
  logic [7:0]  op_a = '0;
  logic [7:0]  op_b = '0;
  logic [15:0] result = '0;
  logic        show_result = 1'b0;
  logic [1:0]  field_sel = '0;
  logic        busy, done;
  logic [6:0]  ss0, ss1, ss2, ss3, ss4, ss5, ss6, ss7;
  logic [6:0]  ss [8];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int m_rem = 0;
  int m_k = 0;
  int m_pa = 0, m_pb = 0, m_pr = 0;
  int m_da = 0, m_db = 0, m_dr = 0;
  bit m_valid = 1'b0;

  logic [6:0] seg_tab [10];

  sseg_bcd_display #(.BLINK_DIV(BD), .BLINK_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .update      (update),
    .op_a        (op_a),
    .op_b        (op_b),
    .result      (result),
    .show_result (show_result),
    .field_sel   (field_sel),
    .busy        (busy),
    .done        (done),
    .ssegment0   (ss0),
    .ssegment1   (ss1),
    .ssegment2   (ss2),
    .ssegment3   (ss3),
    .ssegment4   (ss4),
    .ssegment5   (ss5),
    .ssegment6   (ss6),
    .ssegment7   (ss7)
  );

  always #5 clock = ~clock;

  always_comb begin
    ss[0] = ss0; ss[1] = ss1; ss[2] = ss2; ss[3] = ss3;
    ss[4] = ss4; ss[5] = ss5; ss[6] = ss6; ss[7] = ss7;
  end

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a conversion is a 33-cycle countdown; the display takes the values when it expires
  always @(posedge clock) begin
    if (reset) begin
      m_rem = 0; m_k = 0; m_valid = 0;
      m_da = 0; m_db = 0; m_dr = 0;
    end else begin
      m_k++;
      if (m_rem > 0) begin
        if (m_rem == 1) begin
          m_da = m_pa; m_db = m_pb; m_dr = m_pr; m_valid = 1;
        end
        m_rem--;
      end else if (update) begin
        m_pa = op_a; m_pb = op_b; m_pr = result; m_rem = 33;
      end
    end
  end

  function automatic logic [6:0] exp_seg(input int pos);
    int val, k, p10, dig;
    bit phase, blink;
    phase = ((m_k / BD) % 2) == 1;
    if (!m_valid) return 7'h7F;
    if (show_result) begin
      if (pos > 4) return 7'h7F;
      val = m_dr; k = pos;
      blink = phase && (field_sel == 2'd3);
    end else if (pos >= 5) begin
      val = m_da; k = pos - 5;
      blink = phase && (field_sel == 2'd1);
    end else if (pos <= 2) begin
      val = m_db; k = pos;
      blink = phase && (field_sel == 2'd2);
    end else begin
      return 7'h7F;
    end
    p10 = 1;
    for (int j = 0; j < k; j++) p10 = p10 * 10;
    if (blink || (k > 0 && val < p10)) return 7'h7F;
    dig = (val / p10) % 10;
    return seg_tab[dig];
  endfunction

  // Compare every cycle once the DUT has seen a reset edge
  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, m_rem > 0});
      check("done", {31'd0, done}, {31'd0, m_rem == 1});
      for (int p = 0; p < 8; p++) begin
        check($sformatf("ssegment%0d", p), {25'd0, ss[p]}, {25'd0, exp_seg(p)});
      end
    end
  end

  // Pulse update with the given values and watch 34 cycles; optionally try a second update mid-flight
  task automatic run_conv(input int a, input int b, input int r, input bit second,
                          output int done_at, output int dones, output bit busy_first);
    @(posedge clock); #1;
    op_a = 8'(a); op_b = 8'(b); result = 16'(r); update = 1'b1;
    @(posedge clock); #1;
    update = 1'b0;
    done_at = 0; dones = 0; busy_first = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clock);
      if (i == 1) busy_first = busy;
      if (done === 1'b1) begin
        dones++;
        done_at = i;
      end
      if (second && i == 9) begin
        op_a = 8'd99; op_b = 8'd99; result = 16'd1; update = 1'b1;
      end
      if (second && i == 10) update = 1'b0;
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] e7, input logic [6:0] e6,
                              input logic [6:0] e5, input logic [6:0] e4, input logic [6:0] e3,
                              input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
    check({tag, "_ss7"}, {25'd0, ss7}, {25'd0, e7});
    check({tag, "_ss6"}, {25'd0, ss6}, {25'd0, e6});
    check({tag, "_ss5"}, {25'd0, ss5}, {25'd0, e5});
    check({tag, "_ss4"}, {25'd0, ss4}, {25'd0, e4});
    check({tag, "_ss3"}, {25'd0, ss3}, {25'd0, e3});
    check({tag, "_ss2"}, {25'd0, ss2}, {25'd0, e2});
    check({tag, "_ss1"}, {25'd0, ss1}, {25'd0, e1});
    check({tag, "_ss0"}, {25'd0, ss0}, {25'd0, e0});
  endtask

  initial begin
    int  done_at, dones, blank0, blank7;
    bit  bf;

    reset = 1'b1;
    @(posedge clock); #1;
    chk_en = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check_digits("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("idle_blank_ss0", {25'd0, ss0}, 32'h7F);

    // Operand view with a second update that must be ignored
    run_conv(200, 37, 7400, 1'b1, done_at, dones, bf);
    check("lat_busy_first", {31'd0, bf}, 32'd1);
    check("lat_done_at", done_at, 33);
    check("lat_done_count", dones, 1);
    check("lat_busy_after", {31'd0, busy}, 32'd0);
    check_digits("ops", 7'h24, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h78);

    @(posedge clock); #1;
    show_result = 1'b1;
    @(negedge clock);
    check_digits("res7400", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h19, 7'h40, 7'h40);

    run_conv(1, 2, 65535, 1'b0, done_at, dones, bf);
    check_digits("res65535", 7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12);

    run_conv(0, 0, 0, 1'b0, done_at, dones, bf);
    check_digits("res0", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);

    // Blink on field B in operand view: any 8 consecutive cycles hold 4 blank, 4 lit
    @(posedge clock); #1;
    show_result = 1'b0;
    run_conv(200, 37, 0, 1'b0, done_at, dones, bf);
    @(posedge clock); #1;
    field_sel = 2'd2;
    blank0 = 0; blank7 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (ss0 == 7'h7F) blank0++;
      if (ss7 == 7'h7F) blank7++;
    end
    check("blink_b_count", blank0, 4);
    check("blink_a_steady", blank7, 0);

    // Reset in the middle of a conversion
    @(posedge clock); #1;
    field_sel = 2'd0;
    op_a = 8'd77; op_b = 8'd88; result = 16'd999; update = 1'b1;
    @(posedge clock); #1;
    update = 1'b0;
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_ss0", {25'd0, ss0}, 32'h7F);
    check("midreset_ss5", {25'd0, ss5}, 32'h7F);
    @(posedge clock); #1;
    reset = 1'b0;
    run_conv(12, 3, 36, 1'b0, done_at, dones, bf);
    check("post_reset_done_at", done_at, 33);
    check_digits("post_reset", 7'h7F, 7'h79, 7'h24, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock); #1;
      update = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0: begin op_a = 8'd0; op_b = 8'd255; result = 16'hFFFF; end
        1: begin op_a = 8'($urandom_range(0, 9)); op_b = 8'($urandom_range(0, 99)); result = 16'($urandom_range(0, 999)); end
        default: begin op_a = 8'($urandom); op_b = 8'($urandom); result = 16'($urandom); end
      endcase
      if ($urandom_range(0, 49) == 0) show_result = ~show_result;
      if ($urandom_range(0, 49) == 0) field_sel = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 599) == 0);
    end
    @(posedge clock); #1;
    reset = 1'b0; update = 1'b0;
    repeat (3) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
